alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 218 +++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ALU execute unit: captures one command, computes a 32-bit result, then retires it
// through the register, memory and branch ports in that order before pulsing alu_done.
package alu_exec_pkg;
    typedef enum logic [3:0] {
        ADD          = 4'd0,
        SUBTRACT     = 4'd1,
        XOR          = 4'd2,
        OR           = 4'd3,
        AND          = 4'd4,
        SHIFT_LT_LOG = 4'd5,
        SHIFT_RT_LOG = 4'd6,
        SHIFT_RT_AR  = 4'd7
    } alu_op_code_t;
endpackage

module alu_exec_unit
    import alu_exec_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  alu_op_code_t alu_op_code,
    input  logic [31:0]  alu_input_A,
    input  logic [31:0]  alu_input_B,
    input  logic         alu_reg_out,
    input  logic [4:0]   alu_reg_addr,
    input  logic         alu_mem_out,
    input  logic [31:0]  alu_mem_addr,
    input  logic         alu_pc_jump,
    input  logic         alu_inputs_valid,
    output logic         alu_input_ack,
    output logic         alu_done,
    output logic [4:0]   reg_wr_addr,
    output logic [31:0]  reg_wr_data,
    output logic         reg_wr_valid,
    input  logic         reg_wr_ack,
    output logic [31:0]  mem_wr_addr,
    output logic [31:0]  mem_wr_data,
    output logic         mem_wr_valid,
    input  logic         mem_wr_ack,
    output logic [31:0]  alu_pc_branch_data,
    output logic         alu_pc_branch_data_valid,
    input  logic         alu_pc_branch_data_ack
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXEC   = 3'd1,
        WB_REG = 3'd2,
        WB_MEM = 3'd3,
        BRANCH = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t       state_q;
    alu_op_code_t op_q;
    logic [31:0]  a_q;
    logic [31:0]  b_q;
    logic         reg_en_q;
    logic         mem_en_q;
    logic         br_en_q;
    logic [4:0]   reg_addr_q;
    logic [31:0]  mem_addr_q;
    logic [31:0]  result_q;
    logic         ack_q;
    logic         done_q;
    logic         reg_valid_q;
    logic         mem_valid_q;
    logic         br_valid_q;

    state_t       exec_next_d;
    state_t       after_reg_d;
    state_t       after_mem_d;
    logic [31:0]  result_d;

    // First retirement stage still owed, given which stages remain enabled.
    function automatic state_t route(input logic do_reg, input logic do_mem, input logic do_br);
        state_t nxt;
        if (do_reg) begin
            nxt = WB_REG;
        end else if (do_mem) begin
            nxt = WB_MEM;
        end else if (do_br) begin
            nxt = BRANCH;
        end else begin
            nxt = DONE;
        end
        return nxt;
    endfunction

    function automatic logic [31:0] alu_calc(input alu_op_code_t op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ADD:          r = a + b;
            SUBTRACT:     r = a - b;
            XOR:          r = a ^ b;
            OR:           r = a | b;
            AND:          r = a & b;
            SHIFT_LT_LOG: r = a << b[4:0];
            SHIFT_RT_LOG: r = a >> b[4:0];
            SHIFT_RT_AR:  r = $unsigned($signed(a) >>> b[4:0]);
            default:      r = 32'd0;
        endcase
        return r;
    endfunction

    // Result and successor stages are derived only from the latched command.
    always_comb begin
        result_d    = alu_calc(op_q, a_q, b_q);
        exec_next_d = route(reg_en_q, mem_en_q, br_en_q);
        after_reg_d = route(1'b0, mem_en_q, br_en_q);
        after_mem_d = route(1'b0, 1'b0, br_en_q);
    end

    // Command sequencer; every output is a register set on entry to its stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= ADD;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            reg_en_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            br_en_q     <= 1'b0;
            reg_addr_q  <= 5'd0;
            mem_addr_q  <= 32'd0;
            result_q    <= 32'd0;
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
            reg_valid_q <= 1'b0;
            mem_valid_q <= 1'b0;
            br_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (alu_inputs_valid) begin
                        op_q       <= alu_op_code;
                        a_q        <= alu_input_A;
                        b_q        <= alu_input_B;
                        // x0 is hardwired zero, so a write to it retires as no write at all
                        reg_en_q   <= alu_reg_out && (alu_reg_addr != 5'd0);
                        mem_en_q   <= alu_mem_out;
                        br_en_q    <= alu_pc_jump;
                        reg_addr_q <= alu_reg_addr;
                        mem_addr_q <= alu_mem_addr;
                        ack_q      <= 1'b1;
                        state_q    <= EXEC;
                    end else begin
                        ack_q      <= 1'b0;
                    end
                end
                EXEC: begin
                    ack_q       <= 1'b0;
                    result_q    <= result_d;
                    state_q     <= exec_next_d;
                    reg_valid_q <= (exec_next_d == WB_REG);
                    mem_valid_q <= (exec_next_d == WB_MEM);
                    br_valid_q  <= (exec_next_d == BRANCH);
                    done_q      <= (exec_next_d == DONE);
                end
                WB_REG: begin
                    if (reg_wr_ack) begin
                        reg_valid_q <= 1'b0;
                        state_q     <= after_reg_d;
                        mem_valid_q <= (after_reg_d == WB_MEM);
                        br_valid_q  <= (after_reg_d == BRANCH);
                        done_q      <= (after_reg_d == DONE);
                    end else begin
                        state_q     <= WB_REG;
                    end
                end
                WB_MEM: begin
                    if (mem_wr_ack) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= after_mem_d;
                        br_valid_q  <= (after_mem_d == BRANCH);
                        done_q      <= (after_mem_d == DONE);
                    end else begin
                        state_q     <= WB_MEM;
                    end
                end
                BRANCH: begin
                    if (alu_pc_branch_data_ack) begin
                        br_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        state_q    <= BRANCH;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q       <= 1'b0;
                    done_q      <= 1'b0;
                    reg_valid_q <= 1'b0;
                    mem_valid_q <= 1'b0;
                    br_valid_q  <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign alu_input_ack            = ack_q;
    assign alu_done                 = done_q;
    assign reg_wr_addr              = reg_addr_q;
    assign reg_wr_data              = result_q;
    assign reg_wr_valid             = reg_valid_q;
    assign mem_wr_addr              = mem_addr_q;
    assign mem_wr_data              = result_q;
    assign mem_wr_valid             = mem_valid_q;
    assign alu_pc_branch_data       = result_q;
    assign alu_pc_branch_data_valid = br_valid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected retirement events,
// a negedge monitor pops them as the DUT completes handshakes.
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    typedef struct {
        int          kind;   // 0 reg write, 1 mem write, 2 branch, 3 done
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic         clk;
    logic         reset;
    alu_op_code_t op;
    logic [31:0]  a, b, mem_addr;
    logic         reg_out, mem_out, pc_jump, valid;
    logic [4:0]   reg_addr;
    logic         alu_input_ack, alu_done;
    logic [4:0]   reg_wr_addr;
    logic [31:0]  reg_wr_data, mem_wr_addr, mem_wr_data, br_data;
    logic         reg_wr_valid, mem_wr_valid, br_valid;
    logic         reg_wr_ack, mem_wr_ack, br_ack;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];
    int  ack_mode = 0;
    int  reg_wait = 0;
    int  acks_seen = 0;
    int  dones_seen = 0;
    int  reg_run = 0;
    int  reg_run_last = 0;

    alu_exec_unit dut (
        .clk(clk), .reset(reset), .alu_op_code(op),
        .alu_input_A(a), .alu_input_B(b),
        .alu_reg_out(reg_out), .alu_reg_addr(reg_addr),
        .alu_mem_out(mem_out), .alu_mem_addr(mem_addr),
        .alu_pc_jump(pc_jump), .alu_inputs_valid(valid),
        .alu_input_ack(alu_input_ack), .alu_done(alu_done),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_wr_valid(reg_wr_valid), .reg_wr_ack(reg_wr_ack),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ack(mem_wr_ack),
        .alu_pc_branch_data(br_data), .alu_pc_branch_data_valid(br_valid),
        .alu_pc_branch_data_ack(br_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference result straight from the arithmetic rules.
    function automatic logic [31:0] model(input alu_op_code_t o, input logic [31:0] x,
                                          input logic [31:0] y);
        int          sh;
        logic [31:0] ones;
        sh   = int'(y[4:0]);
        ones = 32'hFFFF_FFFF;
        case (o)
            ADD:          return x + y;
            SUBTRACT:     return x - y;
            XOR:          return x ^ y;
            OR:           return x | y;
            AND:          return x & y;
            SHIFT_LT_LOG: return x << sh;
            SHIFT_RT_LOG: return x >> sh;
            SHIFT_RT_AR:  return (x >> sh) | (x[31] ? ~(ones >> sh) : 32'h0);
            default:      return 32'h0;
        endcase
    endfunction

    task automatic push_cmd(input logic ro, input logic [4:0] ra, input logic mo,
                            input logic [31:0] ma, input logic pj, input logic [31:0] res);
        if (ro && ra != 5'd0) exp_q.push_back('{0, {27'd0, ra}, res});
        if (mo) exp_q.push_back('{1, ma, res});
        if (pj) exp_q.push_back('{2, 32'h0, res});
        exp_q.push_back('{3, 32'h0, 32'h0});
    endtask

    task automatic check_event(input int kind, input logic [31:0] ad, input logic [31:0] da);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: actual kind=%0d addr=%h data=%h required none", kind, ad, da);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr !== ad || e.data !== da) begin
                errors++;
                $display("FAIL retire_event: actual kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h",
                         kind, ad, da, e.kind, e.addr, e.data);
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        chk("retire_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    // mode 0: drop valid and wait for retirement; 1: keep valid high; 2: drop valid, return at once
    task automatic issue(input alu_op_code_t o, input logic [31:0] ia, input logic [31:0] ib,
                         input logic ro, input logic [4:0] ra, input logic mo,
                         input logic [31:0] ma, input logic pj, input logic [31:0] res,
                         input int mode);
        logic got;
        op = o; a = ia; b = ib; reg_out = ro; reg_addr = ra;
        mem_out = mo; mem_addr = ma; pc_jump = pj; valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            got = alu_input_ack;
        end
        chk("input_ack_seen", {31'd0, got}, 32'd1);
        if (got) push_cmd(ro, ra, mo, ma, pj, res);
        if (mode != 1) begin
            valid   = 1'b0;
            op      = alu_op_code_t'(4'($urandom_range(0, 15)));
            a       = $urandom;
            b       = $urandom;
            reg_out = 1'($urandom_range(0, 1));
            reg_addr = 5'($urandom_range(0, 31));
            mem_out = 1'($urandom_range(0, 1));
            mem_addr = $urandom;
            pc_jump = 1'($urandom_range(0, 1));
        end
        if (mode == 0) wait_idle();
    endtask

    // Downstream acknowledge generator; random mode also raises acks while valids are low.
    initial begin
        reg_wr_ack = 1'b0; mem_wr_ack = 1'b0; br_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reg_wr_valid) reg_wait++;
            else reg_wait = 0;
            case (ack_mode)
                0: begin reg_wr_ack = 1'b1; mem_wr_ack = 1'b1; br_ack = 1'b1; end
                1: begin
                    reg_wr_ack = 1'($urandom_range(0, 1));
                    mem_wr_ack = 1'($urandom_range(0, 1));
                    br_ack     = 1'($urandom_range(0, 1));
                end
                2: begin reg_wr_ack = (reg_wait >= 4); mem_wr_ack = 1'b1; br_ack = 1'b1; end
                default: begin reg_wr_ack = 1'b0; mem_wr_ack = 1'b0; br_ack = 1'b0; end
            endcase
        end
    end

    // Monitor: pops the scoreboard on each completed handshake and on alu_done.
    initial begin
        logic        p_ack, p_rv, p_rk, p_mv, p_mk, p_bv, p_bk;
        logic [4:0]  p_ra;
        logic [31:0] p_rd, p_ma, p_md, p_bd;
        int          nv;
        p_ack = 1'b0; p_rv = 1'b0; p_rk = 1'b0; p_mv = 1'b0; p_mk = 1'b0; p_bv = 1'b0; p_bk = 1'b0;
        p_ra = 5'd0; p_rd = 32'd0; p_ma = 32'd0; p_md = 32'd0; p_bd = 32'd0;
        forever begin
            @(negedge clk);
            if (alu_input_ack) begin
                chk("ack_single_pulse", {31'd0, p_ack}, 32'd0);
                acks_seen++;
            end
            nv = int'(reg_wr_valid) + int'(mem_wr_valid) + int'(br_valid) + int'(alu_done);
            if (nv != 0) chk("one_stage_active", 32'(nv), 32'd1);
            if (reg_wr_valid) begin
                if (p_rv && !p_rk) chk("reg_wr_stable", {reg_wr_data ^ p_rd} | {27'd0, reg_wr_addr ^ p_ra}, 32'd0);
                reg_run++;
                if (reg_wr_ack) check_event(0, {27'd0, reg_wr_addr}, reg_wr_data);
            end else if (reg_run != 0) begin
                reg_run_last = reg_run;
                reg_run = 0;
            end
            if (mem_wr_valid) begin
                if (p_mv && !p_mk) chk("mem_wr_stable", (mem_wr_data ^ p_md) | (mem_wr_addr ^ p_ma), 32'd0);
                if (mem_wr_ack) check_event(1, mem_wr_addr, mem_wr_data);
            end
            if (br_valid) begin
                if (p_bv && !p_bk) chk("branch_stable", br_data ^ p_bd, 32'd0);
                if (br_ack) check_event(2, 32'h0, br_data);
            end
            if (alu_done) begin
                check_event(3, 32'h0, 32'h0);
                dones_seen++;
                chk("ack_per_done", 32'(acks_seen), 32'(dones_seen));
            end
            p_ack = alu_input_ack;
            p_rv = reg_wr_valid; p_rk = reg_wr_ack; p_ra = reg_wr_addr; p_rd = reg_wr_data;
            p_mv = mem_wr_valid; p_mk = mem_wr_ack; p_ma = mem_wr_addr; p_md = mem_wr_data;
            p_bv = br_valid;     p_bk = br_ack;     p_bd = br_data;
        end
    end

    initial begin
        logic         seen;
        alu_op_code_t ro_op;
        logic [31:0]  ra_a, ra_b, rm;
        logic [4:0]   rr;
        logic         rro, rmo, rpj;

        reset = 1'b0; valid = 1'b0; op = ADD; a = 32'd0; b = 32'd0;
        reg_out = 1'b0; reg_addr = 5'd0; mem_out = 1'b0; mem_addr = 32'd0; pc_jump = 1'b0;
        ack_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {27'd0, alu_input_ack, alu_done, reg_wr_valid, mem_wr_valid, br_valid}, 32'd0);
        chk("reset_data", reg_wr_data | mem_wr_data | br_data | mem_wr_addr | {27'd0, reg_wr_addr}, 32'd0);

        // ADD wrap to x5 with tied acks; valid already high while reset is released
        op = ADD; a = 32'hFFFF_FFFF; b = 32'd2; reg_out = 1'b1; reg_addr = 5'd5; valid = 1'b1;
        @(posedge clk);
        #1;
        chk("no_ack_in_reset", {31'd0, alu_input_ack}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("lat_ack_cycle1", {31'd0, alu_input_ack}, 32'd1);
        push_cmd(1'b1, 5'd5, 1'b0, 32'h0, 1'b0, 32'h0000_0001);
        valid = 1'b0; a = 32'h1234_5678; b = 32'h9;
        @(posedge clk);
        #1;
        chk("lat_regvalid_cycle2", {30'd0, reg_wr_valid, alu_input_ack}, 32'd2);
        chk("lat_reg_data", reg_wr_data, 32'h0000_0001);
        @(posedge clk);
        #1;
        chk("lat_done_cycle3", {30'd0, alu_done, reg_wr_valid}, 32'd2);
        wait_idle();

        // Arithmetic vs logical right shift of the sign bit
        issue(SHIFT_RT_AR, 32'h8000_0000, 32'h24, 1'b1, 5'd7, 1'b0, 32'h0, 1'b0, 32'hF800_0000, 0);
        issue(SHIFT_RT_LOG, 32'h8000_0000, 32'h24, 1'b1, 5'd8, 1'b0, 32'h0, 1'b0, 32'h0800_0000, 0);

        // Write to x0 is dropped, done follows EXEC directly
        issue(SUBTRACT, 32'd5, 32'd7, 1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFE, 2);
        @(posedge clk);
        #1;
        chk("x0_done_after_exec", {30'd0, alu_done, reg_wr_valid}, 32'd2);
        wait_idle();

        // Register ack delayed three cycles, then memory write to 0x40
        ack_mode = 2;
        issue(XOR, 32'hA5A5_0F0F, 32'h0FF0_1234, 1'b1, 5'd9, 1'b1, 32'h40, 1'b0,
              32'hA5A5_0F0F ^ 32'h0FF0_1234, 0);
        chk("reg_valid_held_cycles", 32'(reg_run_last), 32'd4);

        // valid held high across back-to-back commands with random acks
        ack_mode = 1;
        for (int i = 0; i < 6; i++) begin
            ro_op = alu_op_code_t'(4'($urandom_range(0, 9)));
            ra_a = $urandom; ra_b = $urandom; rr = 5'($urandom_range(0, 31)); rm = $urandom;
            rro = 1'($urandom_range(0, 1)); rmo = 1'($urandom_range(0, 1)); rpj = 1'($urandom_range(0, 1));
            issue(ro_op, ra_a, ra_b, rro, rr, rmo, rm, rpj, model(ro_op, ra_a, ra_b), (i == 5) ? 0 : 1);
        end

        // Reset while a register write waits for its ack
        ack_mode = 3;
        issue(OR, 32'h0000_F000, 32'h0000_000F, 1'b1, 5'd3, 1'b1, 32'h80, 1'b1, 32'h0000_F00F, 2);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = reg_wr_valid;
        end
        chk("wb_reg_reached", {31'd0, seen}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("midop_reset_flags", {27'd0, alu_input_ack, alu_done, reg_wr_valid, mem_wr_valid, br_valid}, 32'd0);
        chk("midop_reset_data", reg_wr_data | mem_wr_addr | {27'd0, reg_wr_addr}, 32'd0);
        exp_q.delete();
        acks_seen = dones_seen;
        ack_mode = 1;
        repeat (6) @(posedge clk);
        #1;

        // Randomized commands, including undefined opcodes and x0 destinations
        for (int i = 0; i < 150; i++) begin
            ro_op = alu_op_code_t'(4'($urandom_range(0, 9)));
            ra_a = $urandom; ra_b = $urandom; rm = $urandom;
            rr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rro = 1'($urandom_range(0, 1)); rmo = 1'($urandom_range(0, 1)); rpj = 1'($urandom_range(0, 1));
            issue(ro_op, ra_a, ra_b, rro, rr, rmo, rm, rpj, model(ro_op, ra_a, ra_b), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
